// File: rtl/bcd_pkg.sv
// Shared BCD constants and the nibble validity check used by the counter and
// the downstream decoder-side checks.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic is_bcd(input logic [3:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register with up/down step, parallel load and a
// combinational wrap flag (9->0 up, 0->9 down) for the next digit.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] digit,
  output logic       wrap
);

  logic [3:0] digit_d;

  always_comb begin
    wrap    = step & (up ? (digit == BCD_MAX) : (digit == BCD_MIN));
    digit_d = digit;
    if (ld) begin
      digit_d = ld_val;
    end else if (step) begin
      if (up) begin
        digit_d = (digit >= BCD_MAX) ? BCD_MIN : digit + 4'd1;
      end else begin
        digit_d = (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= BCD_MIN;
    end else begin
      digit <= digit_d;
    end
  end

endmodule

// File: rtl/bcd_updown_counter_2d.sv
// Two-digit BCD up/down counter with prescaler, checked parallel load,
// terminal-count pulse on 99<->00 wrap and a load-error pulse.
module bcd_updown_counter_2d
  import bcd_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] ones_q,
  output logic [3:0] tens_q,
  output logic       tc,
  output logic       load_err
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          load_ok;
  logic          step;
  logic          ones_wrap, tens_wrap;
  logic          tc_d, load_err_d;

  always_comb begin
    load_ok    = load & is_bcd(load_val[7:4]) & is_bcd(load_val[3:0]);
    // Any load request, valid or not, blocks stepping for that cycle.
    step       = en & ~load & (presc_q == PRESC_LAST);
    tc_d       = ones_wrap & tens_wrap;
    load_err_d = load & ~load_ok;
    presc_d    = presc_q;
    if (load_ok) begin
      presc_d = '0;
    end else if (en & ~load) begin
      presc_d = step ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      tc       <= tc_d;
      load_err <= load_err_d;
    end
  end

  bcd_digit u_ones (
    .clk    (clk),
    .rst    (rst),
    .step   (step),
    .up     (up),
    .ld     (load_ok),
    .ld_val (load_val[3:0]),
    .digit  (ones_q),
    .wrap   (ones_wrap)
  );

  bcd_digit u_tens (
    .clk    (clk),
    .rst    (rst),
    .step   (ones_wrap),
    .up     (up),
    .ld     (load_ok),
    .ld_val (load_val[7:4]),
    .digit  (tens_q),
    .wrap   (tens_wrap)
  );

endmodule

// File: tb/tb_bcd_updown_counter_2d.sv
// Self-checking bench: directed vector table, corner sequences and random
// traffic compared against an arithmetic (0..99 integer) reference model.
module tb_bcd_updown_counter_2d;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b1, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [3:0] ones_q, tens_q;
  logic       tc, load_err;

  int nchecks = 0;
  int nerrors = 0;

  // Reference model state
  int m_val = 0, m_pre = 0;
  bit m_tc = 0, m_err = 0;

  typedef struct {
    logic       en, up, load;
    logic [7:0] lv;
    logic [3:0] ones, tens;
    logic       tc, err;
  } vec_t;
  vec_t tbl[$];

  bcd_updown_counter_2d #(.PRESCALE(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .ones_q   (ones_q),
    .tens_q   (tens_q),
    .tc       (tc),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit e, input bit u, input bit l, input logic [7:0] lv);
    int hi, lo;
    hi = int'(lv[7:4]);
    lo = int'(lv[3:0]);
    m_tc  = 0;
    m_err = 0;
    if (l) begin
      if (hi <= 9 && lo <= 9) begin
        m_val = hi * 10 + lo;
        m_pre = 0;
      end else begin
        m_err = 1;
      end
    end else if (e) begin
      if (m_pre == P - 1) begin
        m_pre = 0;
        if (u) begin
          m_tc  = (m_val == 99);
          m_val = (m_val + 1) % 100;
        end else begin
          m_tc  = (m_val == 0);
          m_val = (m_val + 99) % 100;
        end
      end else begin
        m_pre++;
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 unit later.
  task automatic cyc(input bit e, input bit u, input bit l, input logic [7:0] lv);
    en = e; up = u; load = l; load_val = lv;
    @(posedge clk);
    model_edge(e, u, l, lv);
    #1;
    chk("ones", 8'(ones_q), 8'(m_val % 10));
    chk("tens", 8'(tens_q), 8'(m_val / 10));
    chk("tc", 8'(tc), 8'(m_tc));
    chk("load_err", 8'(load_err), 8'(m_err));
  endtask

  task automatic add(input bit e, input bit u, input bit l, input logic [7:0] lv,
                     input logic [3:0] o, input logic [3:0] t, input bit c, input bit r);
    vec_t v;
    v.en = e; v.up = u; v.load = l; v.lv = lv;
    v.ones = o; v.tens = t; v.tc = c; v.err = r;
    tbl.push_back(v);
  endtask

  initial begin
    int tc_seen;
    // Directed table, starting straight out of reset (prescaler at 0).
    for (int i = 0; i < 3; i++) add(1, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 8'h00, 1, 0, 0, 0);                    // 4th enabled edge: 01
    add(1, 1, 1, 8'h98, 8, 9, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 8'h00, 8, 9, 0, 0);
    add(1, 1, 0, 8'h00, 9, 9, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 8'h00, 9, 9, 0, 0);
    add(1, 1, 0, 8'h00, 0, 0, 1, 0);                    // 99 -> 00 with tc
    for (int i = 0; i < 3; i++) add(1, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 8'h00, 1, 0, 0, 0);
    add(1, 0, 1, 8'h10, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 8'h00, 0, 1, 0, 0);
    add(1, 0, 0, 8'h00, 9, 0, 0, 0);                    // borrow, no tc
    add(1, 0, 1, 8'h3A, 9, 0, 0, 1);                    // rejected load
    add(1, 0, 0, 8'h00, 9, 0, 0, 0);
    add(1, 0, 1, 8'hF5, 9, 0, 0, 1);
    add(1, 0, 0, 8'h00, 9, 0, 0, 0);
    add(1, 0, 0, 8'h00, 9, 0, 0, 0);
    add(1, 0, 0, 8'h00, 8, 0, 0, 0);                    // phase kept through bad loads
    for (int i = 0; i < 3; i++) add(1, 1, 0, 8'h00, 8, 0, 0, 0);
    add(1, 1, 1, 8'h57, 7, 5, 0, 0);                    // load on step-due cycle
    for (int i = 0; i < 3; i++) add(1, 1, 0, 8'h00, 7, 5, 0, 0);
    add(1, 1, 0, 8'h00, 8, 5, 0, 0);
    add(1, 1, 0, 8'h00, 8, 5, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 8'h00, 8, 5, 0, 0);
    add(1, 0, 0, 8'h00, 8, 5, 0, 0);
    add(1, 1, 0, 8'h00, 8, 5, 0, 0);
    add(1, 0, 0, 8'h00, 7, 5, 0, 0);                    // direction sampled at step
    add(0, 0, 1, 8'h00, 0, 0, 0, 0);                    // load works with en=0, no tc
    add(0, 1, 1, 8'h99, 9, 9, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ones", 8'(ones_q), 8'h0);
    chk("reset_tens", 8'(tens_q), 8'h0);
    chk("reset_tc", 8'(tc), 8'h0);
    chk("reset_err", 8'(load_err), 8'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cyc(tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].lv);
      chk($sformatf("tbl%0d_ones", i), 8'(ones_q), 8'(tbl[i].ones));
      chk($sformatf("tbl%0d_tens", i), 8'(tens_q), 8'(tbl[i].tens));
      chk($sformatf("tbl%0d_tc", i), 8'(tc), 8'(tbl[i].tc));
      chk($sformatf("tbl%0d_err", i), 8'(load_err), 8'(tbl[i].err));
    end

    // Full down run 10 -> 00 -> 99: tc must pulse exactly once.
    cyc(1, 0, 1, 8'h10);
    tc_seen = 0;
    for (int i = 0; i < 11 * P; i++) begin
      cyc(1, 0, 0, 8'h00);
      if (tc === 1'b1) tc_seen++;
    end
    chk("down_wrap_val", {tens_q, ones_q}, 8'h99);
    chk("down_tc_count", 8'(tc_seen), 8'd1);

    // Load held high keeps reloading and holds the prescaler at 0.
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 8'h23);
    for (int i = 0; i < P; i++) cyc(1, 1, 0, 8'h00);
    chk("held_load_step", {tens_q, ones_q}, 8'h24);

    // Asynchronous reset in mid-prescale takes effect before the next edge.
    cyc(1, 1, 0, 8'h00);
    cyc(1, 1, 0, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ones", 8'(ones_q), 8'h0);
    chk("async_rst_tens", 8'(tens_q), 8'h0);
    m_val = 0; m_pre = 0; m_tc = 0; m_err = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < P; i++) cyc(1, 1, 0, 8'h00);
    chk("post_rst_first_step", {tens_q, ones_q}, 8'h01);

    // Random traffic against the model, plus digit range invariant.
    for (int i = 0; i < 500; i++) begin
      logic [7:0] lv;
      bit e, l;
      e  = ($urandom_range(0, 9) != 0);
      l  = ($urandom_range(0, 19) == 0);
      lv = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255))
                                        : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      cyc(e, bit'($urandom_range(0, 1)), l, lv);
      chk("range_ones", 8'(ones_q <= 4'd9), 8'd1);
      chk("range_tens", 8'(tens_q <= 4'd9), 8'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bcd_updown_counter_2d.md
Name: bcd_updown_counter_2d

Overview:
Two-digit (00-99) BCD up/down counter that drives the per-digit 4-bit BCD code into the team's BCD-to-7-segment decoders, one decoder per digit.
- Includes a prescaler so counting runs at a divided rate of the system clock.
- Supports a synchronous parallel load with BCD validity checking.
- Emits a one-cycle terminal-count pulse on wrap-around, for cascading or for event flags.

Parameters:
- PRESCALE, default 4, enabled clock cycles per count step; legal range 1..65536 (1 = step on every enabled cycle).
- PW, default $clog2(PRESCALE) (minimum 1), prescaler register width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  count enable; gates the prescaler.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on each step.
- load  in  1  synchronous parallel load request.
- load_val  in  8  [7:4] tens BCD, [3:0] ones BCD.
- ones_q  out  4  ones-digit BCD (0-9), feeds the decoder q3..q0.
- tens_q  out  4  tens-digit BCD (0-9), feeds the decoder q3..q0.
- tc  out  1  one-cycle pulse on wrap (99->00 up, 00->99 down).
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset, asynchronous and active-high: ones_q=0, tens_q=0, tc=0, load_err=0, prescaler=0. Takes effect immediately, including mid-step or mid-load; the first step after release needs a full PRESCALE enabled cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Prescaler:
  - Counts 0..PRESCALE-1 only while en=1 and load=0.
  - A step occurs on the enabled cycle where prescaler==PRESCALE-1; the prescaler returns to 0 at the same edge.
  - en=0 freezes the prescaler and the digits.
- Step when up=1:
  - ones 0-8 → +1.
  - ones 9 → ones=0, tens+1.
  - 99 → 00 with tc=1.
- Step when up=0:
  - ones 1-9 → -1.
  - ones 0 → ones=9, tens-1.
  - 00 → 99 with tc=1.
- Changing up mid-prescale does not reset the prescaler; the new direction applies at the next step.
- tc: asserted for exactly the one cycle in which the wrapped value is first visible; set at the same edge as the digit update. Otherwise 0.
- Load:
  - Priority over stepping; works regardless of en.
  - If both load_val nibbles are ≤9: digits take load_val at the next edge and the prescaler is cleared to 0.
  - If either nibble is >9: digits and prescaler are unchanged, and load_err=1 for that one cycle.
  - A load never asserts tc, even when loading 00 or 99.
  - Holding load high reloads on every cycle and keeps the prescaler at 0.
- Invariant: ones_q and tens_q are never outside 0-9 under any input sequence.
- Latency:
  - Load: 1 cycle.
  - First step after a load or reset: PRESCALE enabled cycles.

Decomposition:
- Shared package bcd_pkg:
  - Constants BCD_MAX=4'd9 and BCD_MIN=4'd0.
  - Helper function is_bcd(nibble) returning the ≤9 check; reused by the decoder-side checks.
- One natural sub-module, bcd_digit: single-digit register plus step logic.
  - Inputs: step, up, ld, ld_val.
  - Output: 4-bit digit, plus borrow/carry out asserted when the step wraps 9→0 or 0→9.
- Top level:
  - Instantiates two bcd_digit instances; the ones carry/borrow out gates the tens step.
  - Owns the prescaler, the load validity check, tc (tens wrap AND ones wrap), and load_err.

Test Plan:
1. Reset/prescale, PRESCALE=4: assert rst mid-count with en=1, up=1, release → digits 00, tc=0; the first step (00→01) occurs on the 4th enabled edge after release; then one step every 4 cycles.
2. Up wrap: load 0x98, en=1, up=1 → 99 after 4 cycles, then 00 with tc=1 for exactly one cycle; tc=0 on the next step (01).
3. Down wrap/borrow: load 0x10, up=0 → 09 (no tc), ..., 00, then 99 with tc=1 single cycle.
4. Invalid load: from 42, load 0x3A → digits stay 42, load_err=1 one cycle, prescaler phase unaffected; load 0xF5 gives the same result.
5. Load priority: load=1 with load_val=0x57 on the exact cycle a step is due → 57 next cycle, no increment, tc=0, next step 4 enabled cycles later (58).
6. Enable/direction: en=0 for 10 cycles mid-prescale → value frozen, prescaler resumes its phase when en returns; toggle up between steps → direction applies at the next step. Run a 500-cycle random sequence and check every cycle that both digits stay ≤9.
